// File: rtl/dmem_mmio_pkg.sv
// rtl/dmem_mmio_pkg.sv - shared MMIO map, status bit indices and UART state encoding
package dmem_mmio_pkg;

    localparam logic [31:0] ADDR_LED    = 32'h8000_0000;
    localparam logic [31:0] ADDR_TX     = 32'h8000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_000C;

    // Decode compares word addresses so the byte offset never matters
    localparam logic [29:0] WORD_LED    = ADDR_LED[31:2];
    localparam logic [29:0] WORD_TX     = ADDR_TX[31:2];
    localparam logic [29:0] WORD_STATUS = ADDR_STATUS[31:2];
    localparam logic [29:0] WORD_CYCLE  = ADDR_CYCLE[31:2];

    localparam int STAT_BUSY  = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_EMPTY = 2;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/dmem_mmio_uart_tx.sv
// rtl/dmem_mmio_uart_tx.sv - UART 8N1 transmitter with byte FIFO, built only when DMEM_MMIO_UART_EN is defined
`ifdef DMEM_MMIO_UART_EN
module uart_tx
    import dmem_mmio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    uart_state_t   state;
    uart_state_t   state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          pop;
    logic          push_ok;
    logic          baud_done;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign busy      = (state != UART_IDLE);
    assign pop       = (state == UART_IDLE) && !empty;
    // A full FIFO still accepts a byte in the cycle the head is popped
    assign push_ok   = push && (!full || pop);
    assign baud_done = (baud_cnt == BAUD_LAST);

    // FIFO storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= UART_IDLE;
        else       state <= state_next;
    end

    // FSM next state and line level
    always_comb begin
        state_next = state;
        tx         = 1'b1;
        case (state)
            UART_IDLE:  if (!empty) state_next = UART_START;
            UART_START: begin
                tx = 1'b0;
                if (baud_done) state_next = UART_DATA;
            end
            UART_DATA: begin
                tx = shreg[0];
                if (baud_done && bit_cnt == 3'd7) state_next = UART_STOP;
            end
            UART_STOP:  if (baud_done) state_next = UART_IDLE;
            default:    state_next = UART_IDLE;
        endcase
    end

    // Bit timing and LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else if (state == UART_IDLE) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            if (pop) shreg <= fifo_mem[rd_ptr];
        end else begin
            baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
            if (state == UART_DATA && baud_done) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data RAM plus LED, UART and cycle counter MMIO; UART present only with DMEM_MMIO_UART_EN
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic [29:0]   word;
    logic          is_mmio;
    logic          sel_led;
    logic          sel_cycle;
    logic [31:0]   cycle_cnt;
    logic [2:0]    status;
    logic          unused_addr_bits;

    assign ram_idx          = addr[AW+1:2];
    assign word             = addr[31:2];
    assign is_mmio          = addr[31];
    assign sel_led          = (word == WORD_LED);
    assign sel_cycle        = (word == WORD_CYCLE);
    assign unused_addr_bits = ^addr[1:0];

    // RAM write; not gated by reset so a store during reset still lands
    always_ff @(posedge clk) begin
        if (we && !is_mmio) ram[ram_idx] <= wdata;
    end

    // LED register
    always_ff @(posedge clk) begin
        if (reset)              leds <= '0;
        else if (we && sel_led) leds <= wdata[7:0];
    end

    // Free-running cycle counter; a write clears it ahead of the increment
    always_ff @(posedge clk) begin
        if (reset)                cycle_cnt <= '0;
        else if (we && sel_cycle) cycle_cnt <= '0;
        else                      cycle_cnt <= cycle_cnt + 32'd1;
    end

`ifdef DMEM_MMIO_UART_EN
    logic sel_tx;
    logic tx_busy;
    logic tx_full;
    logic tx_empty;

    assign sel_tx = (word == WORD_TX);

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (TX_FIFO_DEPTH)
    ) u_uart_tx (
        .clk       (clk),
        .reset     (reset),
        .push      (we && sel_tx),
        .push_data (wdata[7:0]),
        .tx        (uart_tx),
        .busy      (tx_busy),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // Status word gathered from the transmitter
    always_comb begin
        status             = '0;
        status[STAT_BUSY]  = tx_busy;
        status[STAT_FULL]  = tx_full;
        status[STAT_EMPTY] = tx_empty;
    end
`else
    assign uart_tx = 1'b1;

    // Without a transmitter the status reads as permanently empty and idle
    always_comb begin
        status             = '0;
        status[STAT_EMPTY] = 1'b1;
    end
`endif

    // Zero-latency read mux
    always_comb begin
        rdata = '0;
        if (!is_mmio) begin
            rdata = ram[ram_idx];
        end else begin
            case (word)
                WORD_LED:    rdata = {24'h0, leds};
                WORD_STATUS: rdata = {29'h0, status};
                WORD_CYCLE:  rdata = cycle_cnt;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - directed self-checking bench for dmem_mmio
module tb_dmem_mmio;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TX     = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int zeros;
    int guard;
    logic [7:0] rx [5];
    int         rx_start [5];
    logic [7:0] burst [6];
    logic [9:0] frame;

    dmem_mmio #(
        .RAM_WORDS     (256),
        .CLKS_PER_BIT  (4),
        .TX_FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        we   = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        burst[0] = 8'h3C; burst[1] = 8'hA7; burst[2] = 8'h01;
        burst[3] = 8'hFE; burst[4] = 8'h96; burst[5] = 8'h5A;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_uart_tx", 32'(uart_tx), 32'h1);
        rd_chk("reset_status", A_STATUS, 32'h4);
        @(negedge clk);
        reset = 1'b0;
        rd_chk("reset_cycle", A_CYCLE, 32'h0);
        @(negedge clk);
        rd_chk("cycle_first_inc", A_CYCLE, 32'h1);

        // RAM and aliasing
        wr(32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_0x40", 32'h40, 32'hDEAD_BEEF);
        rd_chk("ram_alias_0x440", 32'h440, 32'hDEAD_BEEF);
        rd_chk("ram_byte_0x41", 32'h41, 32'hDEAD_BEEF);
        wr(32'h444, 32'h1234_5678);
        rd_chk("ram_alias_write", 32'h44, 32'h1234_5678);
        rd_chk("ram_neighbour", 32'h40, 32'hDEAD_BEEF);

        // LED register and unmapped MMIO
        wr(A_LED, 32'h1A5);
        #1;
        chk("leds_value", {24'h0, leds}, 32'hA5);
        rd_chk("leds_read", A_LED, 32'hA5);
        rd_chk("leds_read_off3", 32'h8000_0003, 32'hA5);
        wr(32'h8000_0020, 32'hFF);
        rd_chk("unmapped_read", 32'h8000_0020, 32'h0);
        rd_chk("leds_unmapped_write", A_LED, 32'hA5);
        rd_chk("tx_reads_zero", A_TX, 32'h0);

        // Writes during reset: LED suppressed, RAM still written
        @(negedge clk);
        reset = 1'b1; we = 1'b1; addr = A_LED; wdata = 32'h3C;
        @(negedge clk);
        addr = 32'h80; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        we = 1'b0; reset = 1'b0;
        #1;
        chk("leds_after_reset", {24'h0, leds}, 32'h0);
        rd_chk("ram_write_in_reset", 32'h80, 32'hCAFE_F00D);

        // Cycle counter clear and wrap
        wr(A_CYCLE, 32'h1234);
        rd_chk("cycle_clear_n1", A_CYCLE, 32'h0);
        repeat (2) @(negedge clk);
        rd_chk("cycle_clear_n3", A_CYCLE, 32'h2);
        @(negedge clk);
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        chk("cycle_forced", rdata, 32'hFFFF_FFFF);
        release dut.cycle_cnt;
        @(negedge clk);
        #1;
        chk("cycle_wrap", rdata, 32'h0);

`ifdef DMEM_MMIO_UART_EN
        // Single 0x55 frame
        frame = {1'b1, 8'h55, 1'b0};
        wr(A_TX, 32'h55);
        rd_chk("status_queued", A_STATUS, 32'h0);
        for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1;
                chk($sformatf("frame55_bit%0d_clk%0d", j, k), 32'(uart_tx), 32'(frame[j]));
                chk($sformatf("frame55_busy%0d_%0d", j, k), rdata, 32'h5);
            end
        end
        @(negedge clk);
        #1;
        chk("frame55_idle_tx", 32'(uart_tx), 32'h1);
        chk("frame55_idle_status", rdata, 32'h4);

        // Burst of six pushes into a depth-4 FIFO
        fork
            begin
                for (int b = 0; b < 5; b++) wr(A_TX, 32'(burst[b]));
                rd_chk("burst_full", A_STATUS, 32'h3);
                wr(A_TX, 32'(burst[5]));
                rd_chk("burst_still_full", A_STATUS, 32'h3);
            end
            begin
                for (int b = 0; b < 5; b++) begin
                    guard = 0;
                    @(negedge clk);
                    while (uart_tx !== 1'b0 && guard < 200) begin
                        @(negedge clk);
                        guard++;
                    end
                    chk("rx_start_seen", 32'(uart_tx), 32'h0);
                    rx_start[b] = cyc;
                    repeat (5) @(negedge clk);
                    rx[b][0] = uart_tx;
                    for (int i = 1; i < 8; i++) begin
                        repeat (4) @(negedge clk);
                        rx[b][i] = uart_tx;
                    end
                    repeat (4) @(negedge clk);
                    chk("rx_stop", 32'(uart_tx), 32'h1);
                end
            end
        join
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("rx_byte%0d", b), 32'(rx[b]), 32'(burst[b]));
        end
        for (int b = 1; b < 5; b++) begin
            chk($sformatf("rx_spacing%0d", b), 32'(rx_start[b] - rx_start[b-1]), 32'd41);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("overflow_dropped_tx", 32'(uart_tx), 32'h1);
        rd_chk("overflow_dropped_status", A_STATUS, 32'h4);

        // Reset in the middle of a data bit
        wr(A_TX, 32'h00);
        repeat (6) @(negedge clk);
        #1;
        chk("mid_data_low", 32'(uart_tx), 32'h0);
        reset = 1'b1;
        addr  = A_STATUS;
        @(negedge clk);
        #1;
        chk("abort_tx_high", 32'(uart_tx), 32'h1);
        chk("abort_status", rdata, 32'h4);
        reset = 1'b0;
        zeros = 0;
        repeat (50) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) zeros++;
        end
        chk("abort_no_more_bits", 32'(zeros), 32'h0);
`else
        // Transmitter absent: TX writes ignored, line idle, status fixed
        wr(A_TX, 32'h55);
        rd_chk("noutx_status", A_STATUS, 32'h4);
        zeros = 0;
        repeat (45) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) zeros++;
        end
        chk("noutx_line_idle", 32'(zeros), 32'h0);
        rd_chk("noutx_tx_read", A_TX, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
